// File: rtl/alu_arbiter_if.sv
// Requester/ALU-side bundle for alu_arbiter: two request ports, the shared result
// and the registered ALU drive. The master modport is the requester/ALU side.
interface alu_arbiter_if;
    logic       iReq0;
    logic       iReq1;
    logic [3:0] iOpCode0;
    logic [3:0] iOpCode1;
    logic [3:0] iA0;
    logic [3:0] iB0;
    logic [3:0] iA1;
    logic [3:0] iB1;
    logic       oGrant0;
    logic       oGrant1;
    logic       oDone0;
    logic       oDone1;
    logic [3:0] oResultado;
    logic [4:0] oFlags;
    logic [3:0] oAluOpCode;
    logic [3:0] oAluA;
    logic [3:0] oAluB;
    logic [3:0] iAluResultado;
    logic [4:0] iAluFlags;
    logic       oBusy;

    modport master (
        output iReq0, iReq1, iOpCode0, iOpCode1, iA0, iB0, iA1, iB1,
        output iAluResultado, iAluFlags,
        input  oGrant0, oGrant1, oDone0, oDone1, oResultado, oFlags,
        input  oAluOpCode, oAluA, oAluB, oBusy
    );

    modport slave (
        input  iReq0, iReq1, iOpCode0, iOpCode1, iA0, iB0, iA1, iB1,
        input  iAluResultado, iAluFlags,
        output oGrant0, oGrant1, oDone0, oDone1, oResultado, oFlags,
        output oAluOpCode, oAluA, oAluB, oBusy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single fixed-latency ALU: IDLE -> WAIT -> DONE.
// Define ALU_ARB_RR_EN for round-robin; otherwise port 0 has fixed priority.
module alu_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          iReset,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] LAST = 4'(LATENCY - 1);

    state_t     state_q, state_nxt;
    logic [3:0] cnt_q, cnt_nxt;
    logic       grant0_q, grant0_nxt;
    logic       grant1_q, grant1_nxt;
    logic       done0_q, done0_nxt;
    logic       done1_q, done1_nxt;
    logic [3:0] res_q, res_nxt;
    logic [4:0] flags_q, flags_nxt;
    logic [3:0] alu_op_q, alu_op_nxt;
    logic [3:0] alu_a_q, alu_a_nxt;
    logic [3:0] alu_b_q, alu_b_nxt;
    logic       win1;

`ifdef ALU_ARB_RR_EN
    logic ptr_q, ptr_nxt;

    // ptr_q set means port 1 is preferred on a tie.
    always_comb win1 = bus.iReq1 & (~bus.iReq0 | ptr_q);

    // After a completed operation, prefer the port that did not win.
    always_comb begin
        ptr_nxt = ptr_q;
        if (state_q == DONE)
            ptr_nxt = grant0_q;
    end

    always_ff @(posedge clk) begin
        if (iReset)
            ptr_q <= 1'b0;
        else
            ptr_q <= ptr_nxt;
    end
`else
    always_comb win1 = bus.iReq1 & ~bus.iReq0;
`endif

    always_ff @(posedge clk) begin
        if (iReset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            grant0_q <= 1'b0;
            grant1_q <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            res_q    <= '0;
            flags_q  <= '0;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            grant0_q <= grant0_nxt;
            grant1_q <= grant1_nxt;
            done0_q  <= done0_nxt;
            done1_q  <= done1_nxt;
            res_q    <= res_nxt;
            flags_q  <= flags_nxt;
            alu_op_q <= alu_op_nxt;
            alu_a_q  <= alu_a_nxt;
            alu_b_q  <= alu_b_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        grant0_nxt = grant0_q;
        grant1_nxt = grant1_q;
        done0_nxt  = 1'b0;
        done1_nxt  = 1'b0;
        res_nxt    = res_q;
        flags_nxt  = flags_q;
        alu_op_nxt = alu_op_q;
        alu_a_nxt  = alu_a_q;
        alu_b_nxt  = alu_b_q;
        case (state_q)
            IDLE: begin
                if (bus.iReq0 || bus.iReq1) begin
                    state_nxt  = WAIT;
                    cnt_nxt    = '0;
                    grant0_nxt = ~win1;
                    grant1_nxt = win1;
                    alu_op_nxt = win1 ? bus.iOpCode1 : bus.iOpCode0;
                    alu_a_nxt  = win1 ? bus.iA1 : bus.iA0;
                    alu_b_nxt  = win1 ? bus.iB1 : bus.iB0;
                end
            end
            WAIT: begin
                cnt_nxt = cnt_q + 4'd1;
                // Requests are ignored here; a dropped request still completes.
                if (cnt_q == LAST) begin
                    res_nxt   = bus.iAluResultado;
                    flags_nxt = bus.iAluFlags;
                    done0_nxt = grant0_q;
                    done1_nxt = grant1_q;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                grant0_nxt = 1'b0;
                grant1_nxt = 1'b0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.oGrant0    = grant0_q;
    assign bus.oGrant1    = grant1_q;
    assign bus.oDone0     = done0_q;
    assign bus.oDone1     = done1_q;
    assign bus.oResultado = res_q;
    assign bus.oFlags     = flags_q;
    assign bus.oAluOpCode = alu_op_q;
    assign bus.oAluA      = alu_a_q;
    assign bus.oAluB      = alu_b_q;
    assign bus.oBusy      = (state_q != IDLE);

    a_grant_onehot: assert property (@(posedge clk) disable iff (iReset)
        !(grant0_q && grant1_q));
    a_done_granted: assert property (@(posedge clk) disable iff (iReset)
        (!done0_q || grant0_q) && (!done1_q || grant1_q));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at LATENCY=1, one at LATENCY=3,
// each in front of a behavioural ALU (op 1 = A+B, op 2 = A-B, flags = {3'b0,carry,zero}).
module tb_alu_arbiter;

    logic clk;
    logic rst;
    int   errs;
    int   checks;

    alu_arbiter_if b1();
    alu_arbiter_if b3();

    alu_arbiter #(.LATENCY(1)) u_dut1 (.clk(clk), .iReset(rst), .bus(b1));
    alu_arbiter #(.LATENCY(3)) u_dut3 (.clk(clk), .iReset(rst), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] w;
        w = '0;
        case (op)
            4'h1:    w = {1'b0, a} + {1'b0, b};
            4'h2:    w = {1'b0, a} - {1'b0, b};
            default: w = '0;
        endcase
        return {3'b000, w[4], (w[3:0] == 4'h0), w[3:0]};
    endfunction

    // LATENCY=1 ALU: result settles combinationally before the next edge.
    assign {b1.iAluFlags, b1.iAluResultado} = alu_f(b1.oAluOpCode, b1.oAluA, b1.oAluB);

    // LATENCY=3 ALU: two register stages behind the combinational result.
    logic [8:0] d3a, d3b;
    always_ff @(posedge clk) begin
        d3a <= alu_f(b3.oAluOpCode, b3.oAluA, b3.oAluB);
        d3b <= d3a;
    end
    assign {b3.iAluFlags, b3.iAluResultado} = d3b;

    logic [25:0] outs1, outs3;
    assign outs1 = {b1.oGrant0, b1.oGrant1, b1.oDone0, b1.oDone1, b1.oResultado, b1.oFlags,
                    b1.oAluOpCode, b1.oAluA, b1.oAluB, b1.oBusy};
    assign outs3 = {b3.oGrant0, b3.oGrant1, b3.oDone0, b3.oDone1, b3.oResultado, b3.oFlags,
                    b3.oAluOpCode, b3.oAluA, b3.oAluB, b3.oBusy};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errs, checks);
        $fatal(1, "watchdog");
    end

    int         nev;
    int         ev_tick [3];
    logic       ev_port [3];
    logic [3:0] ev_res  [3];
    logic       found;
    logic [8:0] cap;
    int         nd;
    logic       exp_port;

    initial begin
        errs = 0;
        checks = 0;
        rst = 1'b1;
        b1.iReq0 = 0; b1.iReq1 = 0; b1.iOpCode0 = 0; b1.iOpCode1 = 0;
        b1.iA0 = 0; b1.iB0 = 0; b1.iA1 = 0; b1.iB1 = 0;
        b3.iReq0 = 0; b3.iReq1 = 0; b3.iOpCode0 = 0; b3.iOpCode1 = 0;
        b3.iA0 = 0; b3.iB0 = 0; b3.iA1 = 0; b3.iB1 = 0;

        // reset and idle
        tick();
        tick();
        chk("rst_b1", 32'(outs1), 0);
        chk("rst_b3", 32'(outs3), 0);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("idle_b1", 32'(outs1), 0);
            chk("idle_b3", 32'(outs3), 0);
        end

        // single request, LATENCY=1: 3+5
        b1.iOpCode0 = 4'h1; b1.iA0 = 4'h3; b1.iB0 = 4'h5; b1.iReq0 = 1'b1;
        tick();
        chk("t2_grant", {b1.oGrant0, b1.oGrant1, b1.oDone0, b1.oDone1, b1.oBusy}, 5'b10001);
        chk("t2_alu_drive", {b1.oAluOpCode, b1.oAluA, b1.oAluB}, 12'h135);
        tick();
        chk("t2_done", {b1.oGrant0, b1.oGrant1, b1.oDone0, b1.oDone1, b1.oBusy}, 5'b10101);
        chk("t2_result", {b1.oFlags, b1.oResultado}, {5'h00, 4'h8});
        b1.iReq0 = 1'b0;
        tick();
        chk("t2_idle", {b1.oGrant0, b1.oGrant1, b1.oDone0, b1.oDone1, b1.oBusy}, 5'b00000);
        chk("t2_hold", b1.oResultado, 4'h8);

        // simultaneous requests, LATENCY=3: port0 2+2, port1 9-4
        b3.iOpCode0 = 4'h1; b3.iA0 = 4'h2; b3.iB0 = 4'h2;
        b3.iOpCode1 = 4'h2; b3.iA1 = 4'h9; b3.iB1 = 4'h4;
        b3.iReq0 = 1'b1; b3.iReq1 = 1'b1;
        nev = 0;
        for (int n = 1; n <= 16; n++) begin
            tick();
            chk("t3_mutex", b3.oGrant0 & b3.oGrant1, 0);
            if (b3.oDone0 || b3.oDone1) begin
                if (nev < 3) begin
                    ev_tick[nev] = n;
                    ev_port[nev] = b3.oDone1;
                    ev_res[nev]  = b3.oResultado;
                end
                nev++;
            end
        end
        chk("t3_nev", nev, 3);
        for (int i = 0; i < 3; i++) begin
`ifdef ALU_ARB_RR_EN
            exp_port = (i == 1);
`else
            exp_port = 1'b0;
`endif
            chk("t3_tick", ev_tick[i], 4 + 5 * i);
            chk("t3_port", ev_port[i], exp_port);
            chk("t3_res", ev_res[i], exp_port ? 4'h5 : 4'h4);
        end
        b3.iReq0 = 1'b0;
        found = 1'b0;
        cap = '0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (b3.oDone1) begin
                found = 1'b1;
                cap = {b3.oFlags, b3.oResultado};
            end
        end
        chk("t3_port1_served", found, 1);
        chk("t3_port1_res", cap, {5'h00, 4'h5});
        b3.iReq1 = 1'b0;
        tick();
        tick();
        chk("t3_idle", b3.oBusy, 0);

        // request dropped during WAIT: port1 3-5
        b3.iOpCode1 = 4'h2; b3.iA1 = 4'h3; b3.iB1 = 4'h5; b3.iReq1 = 1'b1;
        tick();
        chk("t4_grant", {b3.oGrant0, b3.oGrant1, b3.oBusy}, 3'b011);
        tick();
        b3.iReq1 = 1'b0;
        tick();
        chk("t4_no_early_done", b3.oDone1, 0);
        tick();
        chk("t4_done", {b3.oDone0, b3.oDone1, b3.oGrant1}, 3'b011);
        chk("t4_result", {b3.oFlags, b3.oResultado}, {5'b00010, 4'hE});
        tick();
        chk("t4_idle", {b3.oBusy, b3.oGrant1, b3.oDone1}, 3'b000);
        tick();
        chk("t4_stay_idle", {b3.oBusy, b3.oGrant0, b3.oGrant1}, 3'b000);

        // reset mid-operation, then a normal request: 15+1 wraps to 0
        b3.iOpCode0 = 4'h1; b3.iA0 = 4'h6; b3.iB0 = 4'h7; b3.iReq0 = 1'b1;
        tick();
        chk("t5_grant", {b3.oGrant0, b3.oGrant1, b3.oBusy}, 3'b101);
        tick();
        rst = 1'b1;
        tick();
        chk("t5_rst_b3", 32'(outs3), 0);
        chk("t5_rst_b1", 32'(outs1), 0);
        rst = 1'b0;
        b3.iA0 = 4'hF; b3.iB0 = 4'h1;
        tick();
        chk("t5_regrant", {b3.oGrant0, b3.oBusy, b3.oAluOpCode, b3.oAluA, b3.oAluB}, {2'b11, 12'h1F1});
        tick();
        chk("t5_wait1", b3.oDone0, 0);
        tick();
        chk("t5_wait2", b3.oDone0, 0);
        tick();
        chk("t5_done", {b3.oDone0, b3.oGrant0}, 2'b11);
        chk("t5_result", {b3.oFlags, b3.oResultado}, {5'b00011, 4'h0});
        b3.iReq0 = 1'b0;
        tick();
        chk("t5_idle", b3.oBusy, 0);

        // back-to-back on port 0: 1+1 three times
        b3.iOpCode0 = 4'h1; b3.iA0 = 4'h1; b3.iB0 = 4'h1; b3.iReq0 = 1'b1;
        nd = 0;
        for (int n = 1; n <= 14; n++) begin
            tick();
            chk("t6_gnt_busy", {b3.oGrant0, b3.oBusy}, (n % 5 != 0) ? 2'b11 : 2'b00);
            if (b3.oDone0) begin
                nd++;
                chk("t6_res", b3.oResultado, 4'h2);
            end
        end
        b3.iReq0 = 1'b0;
        tick();
        chk("t6_ndone", nd, 3);
        chk("t6_idle", {b3.oGrant0, b3.oBusy}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single ALU instance between two requesters: the control unit (port 0) and an auxiliary requester such as a debug or I/O sequencer (port 1). It accepts one operation at a time, drives the ALU operand and opcode inputs, waits a fixed ALU latency, then captures the result and flags and returns them to the winning requester with a one-cycle done pulse. The block sits between the requesters and the ALU, and runs on the same clock as the ALU.

## Interface
Parameters:
- LATENCY, 1: ALU edges from operand issue to valid result; legal range 1..15.

Ports:
- clk  in  1  system clock; the ALU clock domain.
- iReset  in  1  synchronous, active-high reset.
- iReq0 / iReq1  in  1  request from port 0 / port 1; held high until the matching done.
- iOpCode0 / iOpCode1  in  4  opcode; stable while the request is high.
- iA0, iB0 / iA1, iB1  in  4 each  operands; stable while the request is high.
- oGrant0 / oGrant1  out  1  high from grant until end of DONE; at most one high.
- oDone0 / oDone1  out  1  one-cycle pulse; oResultado and oFlags are valid.
- oResultado  out  4  result of the last completed operation; held until the next completion.
- oFlags  out  5  flags of the last completed operation; held likewise.
- oAluOpCode, oAluA, oAluB  out  4 each  registered drive to the ALU.
- iAluResultado  in  4  from the ALU.
- iAluFlags  in  5  from the ALU.
- oBusy  out  1  high when the state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - With no request, stay in IDLE.
  - With one or both requests high, choose the winner (see Configuration).
  - In the same edge, register the winner's opcode and operands into oAlu*, set oGrantN, clear the counter, and go to WAIT.
- WAIT:
  - The counter increments each edge.
  - On the edge where the counter equals LATENCY-1:
    - capture iAluResultado into oResultado and iAluFlags into oFlags;
    - set oDoneN for the granted port;
    - go to DONE.
- DONE:
  - Done is high for this one cycle only.
  - On the next edge, clear grant and done, update the round-robin pointer, and go to IDLE.
- Requests are re-arbitrated only in IDLE, so a request still high during DONE counts as a new request afterwards.
- oAlu* hold the issued values until the next grant; no op is inserted.
- If the granted requester drops its request during WAIT, the operation still completes and done still pulses; there is no abort.
- A request that is not granted stays pending and has no side effects.
- All arithmetic is done by the ALU; this block only moves data and does not modify widths.

## Timing
- Reset values: every output is 0, state is IDLE, counter is 0, round-robin pointer is 0 (port 0 preferred).
- Request sampled high at edge E, in IDLE:
  - grant is visible after E;
  - oDone is high in the cycle after edge E+LATENCY;
  - state is back in IDLE after edge E+LATENCY+1.
- Earliest next grant is at edge E+LATENCY+2, so the throughput is one operation per LATENCY+2 cycles.
- Reset asserted mid-operation: on the next edge all outputs are 0, state is IDLE, and the in-flight result is discarded with no done pulse.
- Both requests arriving at the same edge: exactly one is granted. The other must wait at least LATENCY+2 cycles.

## Configuration
- ALU_ARB_RR_EN defined:
  - Round-robin arbitration; after each completed operation the pointer moves to the port that did not win.
  - With continuous requests on both ports, grants alternate 0,1,0,1.
- ALU_ARB_RR_EN undefined:
  - Fixed priority; port 0 always wins when both request.
  - Port 1 is served only when iReq0 is low in IDLE.
  - The pointer logic is not instantiated.

## Test plan
The bench uses a behavioural ALU model with latency LATENCY, where opcode 4'h1 gives A+B and 4'h2 gives A-B.
- Reset and idle:
  - iReset high for 2 cycles, then low with no requests.
  - All outputs stay 0, oBusy=0, and no done pulses occur.
- Single request, LATENCY=1:
  - Port 0 requests opcode 4'h1 with A=3, B=5.
  - oGrant0 is high after the next edge; oDone0 pulses exactly 2 edges after the request is sampled; oResultado=4'h8.
  - Port 1 outputs stay low.
- Simultaneous requests, LATENCY=3:
  - Port 0 requests 4'h1 with 2,2; port 1 requests 4'h2 with 9,4, both held high.
  - With ALU_ARB_RR_EN: port 0 done with result 4, then port 1 done with result 5, then port 0 again; results are spaced 5 cycles apart.
  - Without the macro: port 0 is served repeatedly and port 1 is never served until iReq0 drops.
- Request dropped during WAIT:
  - iReq1 is deasserted one cycle after the grant.
  - oDone1 still pulses with the correct result, and the FSM returns to IDLE.
- Reset mid-operation:
  - iReset is asserted in WAIT with LATENCY=3.
  - No done pulse occurs, all outputs are 0 after the edge, and the next request is served normally.
- Back-to-back requests on one port:
  - iReq0 is held high for 3 operations.
  - Grants are spaced LATENCY+2 cycles apart, and oGrant0 is low for exactly one cycle between them, in IDLE.
